// File: rtl/sd_cmd_issuer_pkg.sv
// Shared definitions for the SD command issuer: register map, NISR bits,
// result encodings and the sequencer state set.
package sd_cmd_issuer_pkg;

  localparam logic [7:0] REG_ARG   = 8'h00;
  localparam logic [7:0] REG_CMD   = 8'h04;
  localparam logic [7:0] REG_RESP1 = 8'h0c;
  localparam logic [7:0] REG_NISR  = 8'h30;
  localparam logic [7:0] REG_EISR  = 8'h34;

  localparam int NISR_CC = 0;
  localparam int NISR_EI = 15;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERR     = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_ARG,
    ST_RD_NISR,
    ST_POLL_WAIT,
    ST_RD_EISR,
    ST_CLR_EISR,
    ST_RD_RESP,
    ST_CLR_NISR,
    ST_DONE
  } state_t;

  function automatic logic is_access_state(state_t s);
    return s inside {ST_WR_CMD, ST_WR_ARG, ST_RD_NISR, ST_RD_EISR,
                     ST_CLR_EISR, ST_RD_RESP, ST_CLR_NISR};
  endfunction

endpackage

// File: rtl/sd_cmd_issuer_wbm.sv
// One-shot Wishbone single-access engine: latches an access on start, holds it
// until ack, then drops the bus for at least one cycle before the next start.
module sd_cmd_issuer_wbm (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [7:0]  adr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [7:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i
);

  logic        cyc_reg;
  logic [7:0]  adr_reg;
  logic        we_reg;
  logic [31:0] dat_reg;

  // start is ignored while an access is open; the ack edge itself never
  // launches a new access, which gives the mandatory idle cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cyc_reg <= 1'b0;
      adr_reg <= 8'h00;
      we_reg  <= 1'b0;
      dat_reg <= 32'h0;
    end else if (cyc_reg) begin
      if (wbm_ack_i) begin
        cyc_reg <= 1'b0;
        adr_reg <= 8'h00;
        we_reg  <= 1'b0;
        dat_reg <= 32'h0;
      end
    end else if (start) begin
      cyc_reg <= 1'b1;
      adr_reg <= adr;
      we_reg  <= we;
      dat_reg <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign wbm_sel_o[gi] = cyc_reg;
    end
  endgenerate

  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_dat_o = dat_reg;
  assign busy      = cyc_reg;
  assign done      = cyc_reg & wbm_ack_i;
  assign rdata     = wbm_dat_i;

endmodule

// File: rtl/sd_cmd_issuer.sv
// Runs one SD command over the controller's Wishbone slave and reports the result.
// Optional poll timeout enabled by defining SD_CMD_ISSUER_TIMEOUT_EN.
module sd_cmd_issuer
  import sd_cmd_issuer_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic [15:0] req_cmd_i,
  input  logic [31:0] req_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic [31:0] resp_o,
  output logic [15:0] eisr_o,
  output logic [7:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i
);

  state_t      state_reg, state_next;
  logic [15:0] cmd_reg;
  logic [31:0] arg_reg;
  logic [7:0]  gap_reg;
  logic [1:0]  status_reg;
  logic [31:0] resp_reg;
  logic [15:0] eisr_reg;

  logic        acc_req;
  logic [7:0]  acc_adr;
  logic        acc_we;
  logic [31:0] acc_wdata;
  logic        eng_busy;
  logic        eng_done;
  logic [31:0] eng_rdata;
  logic        timeout_hit;
  logic        accept;

  assign accept = (state_reg == ST_IDLE) && req_i;

  sd_cmd_issuer_wbm u_wbm (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start     (acc_req & ~eng_busy),
    .adr       (acc_adr),
    .we        (acc_we),
    .wdata     (acc_wdata),
    .busy      (eng_busy),
    .done      (eng_done),
    .rdata     (eng_rdata),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i)
  );

`ifdef SD_CMD_ISSUER_TIMEOUT_EN
  logic [15:0] poll_cnt_reg;

  // Saturates at POLL_MAX; the current read is the last one allowed when
  // POLL_MAX-1 reads have already completed.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || accept)
      poll_cnt_reg <= 16'h0;
    else if (state_reg == ST_RD_NISR && eng_done && poll_cnt_reg != 16'(POLL_MAX))
      poll_cnt_reg <= poll_cnt_reg + 16'h1;
  end

  assign timeout_hit = (poll_cnt_reg >= 16'(POLL_MAX - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    acc_adr    = 8'h00;
    acc_we     = 1'b0;
    acc_wdata  = 32'h0;
    case (state_reg)
      ST_IDLE:      if (req_i) state_next = ST_WR_CMD;
      ST_WR_CMD: begin
        acc_adr   = REG_CMD;
        acc_we    = 1'b1;
        acc_wdata = {16'h0, cmd_reg};
        if (eng_done) state_next = ST_WR_ARG;
      end
      ST_WR_ARG: begin
        acc_adr   = REG_ARG;
        acc_we    = 1'b1;
        acc_wdata = arg_reg;
        if (eng_done) state_next = ST_RD_NISR;
      end
      ST_RD_NISR: begin
        acc_adr = REG_NISR;
        if (eng_done) begin
          if (eng_rdata[NISR_EI])      state_next = ST_RD_EISR;
          else if (eng_rdata[NISR_CC]) state_next = ST_RD_RESP;
          else if (timeout_hit)        state_next = ST_CLR_NISR;
          else                         state_next = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: if (gap_reg == 8'(POLL_GAP - 1)) state_next = ST_RD_NISR;
      ST_RD_EISR: begin
        acc_adr = REG_EISR;
        if (eng_done) state_next = ST_CLR_EISR;
      end
      ST_CLR_EISR: begin
        acc_adr = REG_EISR;
        acc_we  = 1'b1;
        if (eng_done) state_next = ST_CLR_NISR;
      end
      ST_RD_RESP: begin
        acc_adr = REG_RESP1;
        if (eng_done) state_next = ST_CLR_NISR;
      end
      ST_CLR_NISR: begin
        acc_adr = REG_NISR;
        acc_we  = 1'b1;
        if (eng_done) state_next = ST_DONE;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  assign acc_req = is_access_state(state_reg);

  // Results are cleared on acceptance and only filled from matching read acks.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cmd_reg    <= 16'h0;
      arg_reg    <= 32'h0;
      gap_reg    <= 8'h0;
      status_reg <= STATUS_OK;
      resp_reg   <= 32'h0;
      eisr_reg   <= 16'h0;
    end else begin
      gap_reg <= (state_reg == ST_POLL_WAIT) ? gap_reg + 8'd1 : 8'd0;
      if (accept) begin
        cmd_reg    <= req_cmd_i;
        arg_reg    <= req_arg_i;
        status_reg <= STATUS_OK;
        resp_reg   <= 32'h0;
        eisr_reg   <= 16'h0;
      end
      if (eng_done) begin
        case (state_reg)
          ST_RD_NISR: begin
            if (eng_rdata[NISR_EI])
              status_reg <= STATUS_ERR;
            else if (!eng_rdata[NISR_CC] && timeout_hit)
              status_reg <= STATUS_TIMEOUT;
          end
          ST_RD_EISR: eisr_reg <= eng_rdata[15:0];
          ST_RD_RESP: resp_reg <= eng_rdata;
          default: ;
        endcase
      end
    end
  end

  assign busy_o   = (state_reg != ST_IDLE);
  assign done_o   = (state_reg == ST_DONE);
  assign status_o = status_reg;
  assign resp_o   = resp_reg;
  assign eisr_o   = eisr_reg;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Directed bench for sd_cmd_issuer: table of command scenarios against a small
// register-slave model, plus hand sequences for request hold, polling and reset.
module tb_sd_cmd_issuer;

  localparam int GAP  = 4;
  localparam int PMAX = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic [15:0] req_cmd_i = 16'h0;
  logic [31:0] req_arg_i = 32'h0;
  logic        busy_o, done_o;
  logic [1:0]  status_o;
  logic [31:0] resp_o;
  logic [15:0] eisr_o;
  logic [7:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  sd_cmd_issuer #(.POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i),
    .req_cmd_i(req_cmd_i), .req_arg_i(req_arg_i), .busy_o(busy_o),
    .done_o(done_o), .status_o(status_o), .resp_o(resp_o), .eisr_o(eisr_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // ---------------- slave model ----------------
  int          cfg_zero_polls = 0;
  logic [15:0] cfg_nisr = 16'h0;
  logic [15:0] cfg_eisr = 16'h0;
  logic [31:0] cfg_resp = 32'h0;
  int          cfg_arg_delay = 1;
  int          nisr_reads = 0;
  int          wcnt = 0;
  int          cur_dly;
  logic        ack_reg = 1'b0;
  logic [31:0] rd_reg = 32'h0;

  assign wbm_ack_i = ack_reg;
  assign wbm_dat_i = ack_reg ? rd_reg : 32'hDEAD_BEEF;
  assign cur_dly   = (wbm_we_o && wbm_adr_o == 8'h00) ? cfg_arg_delay : 1;

  always @(posedge wb_clk_i) begin
    if (ack_reg) ack_reg <= 1'b0;
    else if (wbm_cyc_o && wbm_stb_o) begin
      if (wcnt >= cur_dly - 1) begin
        ack_reg <= 1'b1;
        wcnt    <= 0;
        case (wbm_adr_o)
          8'h30:   rd_reg <= (nisr_reads < cfg_zero_polls) ? 32'h0 : {16'h0, cfg_nisr};
          8'h34:   rd_reg <= {16'h0, cfg_eisr};
          8'h0c:   rd_reg <= cfg_resp;
          default: rd_reg <= 32'h5555_AAAA;
        endcase
        if (!wbm_we_o && wbm_adr_o == 8'h30) nisr_reads <= nisr_reads + 1;
      end else wcnt <= wcnt + 1;
    end else wcnt <= 0;
  end

  // ---------------- bus monitor ----------------
  typedef struct { logic we; logic [7:0] adr; logic [31:0] dat; int len; bit stable; int gap; } acc_t;
  acc_t        log_q[$];
  acc_t        cur;
  bit          prev_stb = 1'b0;
  int          idle_cnt = 100;
  int          sel_err = 0;
  int          done_cnt = 0;

  always @(negedge wb_clk_i) begin
    if (wbm_stb_o) begin
      if (!prev_stb) begin
        cur.we = wbm_we_o; cur.adr = wbm_adr_o; cur.dat = wbm_dat_o;
        cur.len = 1; cur.stable = 1'b1; cur.gap = idle_cnt;
      end else begin
        cur.len++;
        if (wbm_we_o != cur.we || wbm_adr_o != cur.adr || wbm_dat_o != cur.dat) cur.stable = 1'b0;
      end
      if (wbm_sel_o != 4'hF || !wbm_cyc_o) sel_err++;
      if (wbm_ack_i) log_q.push_back(cur);
      idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (wbm_sel_o != 4'h0 || wbm_cyc_o) sel_err++;
    end
    prev_stb = wbm_stb_o;
    if (done_o) done_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, input int t0, output int dc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_o) begin ok = 1'b1; break; end
      step();
    end
    dc = cyc_cnt - t0;
  endtask

  task automatic apply_reset(input int n);
    wb_rst_i = 1'b0;
    req_i = 1'b0;
    repeat (n) step();
    wb_rst_i = 1'b1;
    step();
  endtask

  typedef struct {
    logic [15:0] cmd; logic [31:0] arg; int zero_polls; logic [15:0] nisr;
    logic [15:0] eisr; logic [31:0] resp; int arg_delay;
    logic [1:0] exp_status; logic [31:0] exp_resp; logic [15:0] exp_eisr;
    int exp_acc; int exp_done;
  } vec_t;

  vec_t vecs[5];
  acc_t exp_q[$];

  // Expected access list from the scenario, in the order the command protocol requires.
  task automatic build_expected(input vec_t v);
    acc_t a;
    exp_q.delete();
    a.stable = 1'b1; a.gap = 0;
    a.we = 1; a.adr = 8'h04; a.dat = {16'h0, v.cmd}; a.len = 2;           exp_q.push_back(a);
    a.we = 1; a.adr = 8'h00; a.dat = v.arg; a.len = v.arg_delay + 1;     exp_q.push_back(a);
    for (int i = 0; i <= v.zero_polls; i++) begin
      a.we = 0; a.adr = 8'h30; a.dat = 0; a.len = 2;                      exp_q.push_back(a);
    end
    if (v.nisr[15]) begin
      a.we = 0; a.adr = 8'h34; a.len = 2;                                 exp_q.push_back(a);
      a.we = 1; a.adr = 8'h34; a.dat = 0;                                 exp_q.push_back(a);
    end else begin
      a.we = 0; a.adr = 8'h0c; a.len = 2;                                 exp_q.push_back(a);
    end
    a.we = 1; a.adr = 8'h30; a.dat = 0; a.len = 2;                        exp_q.push_back(a);
  endtask

  task automatic start_cmd(input logic [15:0] cmd, input logic [31:0] arg, output int t0);
    req_cmd_i = cmd;
    req_arg_i = arg;
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    t0 = cyc_cnt;
  endtask

  // ---------------- test ----------------
  initial begin
    int  t0, dc;
    bit  ok;
    int  d0;

    vecs[0] = '{16'h0119, 32'h0000_0800, 0, 16'h0001, 16'h0000, 32'h0000_0900, 1, 2'b00, 32'h0000_0900, 16'h0000, 5, 15};
    vecs[1] = '{16'h0D1A, 32'h1234_5678, 3, 16'h0001, 16'h0000, 32'hCAFE_F00D, 1, 2'b00, 32'hCAFE_F00D, 16'h0000, 8, 36};
    vecs[2] = '{16'h111B, 32'h0000_0010, 0, 16'h8001, 16'h0002, 32'h7777_7777, 1, 2'b01, 32'h0000_0000, 16'h0002, 6, 18};
    vecs[3] = '{16'h0C1B, 32'hA5A5_5A5A, 0, 16'h0001, 16'h0000, 32'h0000_0F00, 5, 2'b00, 32'h0000_0F00, 16'h0000, 5, 19};
    vecs[4] = '{16'h371A, 32'hFFFF_0001, 1, 16'h8000, 16'hABCD, 32'h1111_2222, 1, 2'b01, 32'h0000_0000, 16'hABCD, 7, 25};

    // Reset state
    apply_reset(3);
    chk("rst_cyc", {31'h0, wbm_cyc_o}, 0);
    chk("rst_stb", {31'h0, wbm_stb_o}, 0);
    chk("rst_sel", {28'h0, wbm_sel_o}, 0);
    chk("rst_we", {31'h0, wbm_we_o}, 0);
    chk("rst_adr", {24'h0, wbm_adr_o}, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_busy", {31'h0, busy_o}, 0);
    chk("rst_done", {31'h0, done_o}, 0);
    chk("rst_status", {30'h0, status_o}, 0);
    chk("rst_resp", resp_o, 0);
    chk("rst_eisr", {16'h0, eisr_o}, 0);

    // Table-driven scenarios
    for (int vi = 0; vi < 5; vi++) begin
      vec_t v;
      v = vecs[vi];
      cfg_zero_polls = v.zero_polls; cfg_nisr = v.nisr; cfg_eisr = v.eisr;
      cfg_resp = v.resp; cfg_arg_delay = v.arg_delay;
      nisr_reads = 0; sel_err = 0; log_q.delete();
      start_cmd(v.cmd, v.arg, t0);
      chk($sformatf("v%0d_busy_accept", vi), {31'h0, busy_o}, 1);
      wait_done(400, t0, dc, ok);
      chk($sformatf("v%0d_done_seen", vi), {31'h0, ok}, 1);
      chk($sformatf("v%0d_done_cycle", vi), dc, v.exp_done);
      chk($sformatf("v%0d_busy_done", vi), {31'h0, busy_o}, 1);
      chk($sformatf("v%0d_status", vi), {30'h0, status_o}, {30'h0, v.exp_status});
      chk($sformatf("v%0d_resp", vi), resp_o, v.exp_resp);
      chk($sformatf("v%0d_eisr", vi), {16'h0, eisr_o}, {16'h0, v.exp_eisr});
      build_expected(v);
      chk($sformatf("v%0d_acc_count", vi), log_q.size(), v.exp_acc);
      chk($sformatf("v%0d_exp_count", vi), exp_q.size(), v.exp_acc);
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        chk($sformatf("v%0d_a%0d_adr", vi, i), {24'h0, log_q[i].adr}, {24'h0, exp_q[i].adr});
        chk($sformatf("v%0d_a%0d_we", vi, i), {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
        if (exp_q[i].we) chk($sformatf("v%0d_a%0d_dat", vi, i), log_q[i].dat, exp_q[i].dat);
        chk($sformatf("v%0d_a%0d_len", vi, i), log_q[i].len, exp_q[i].len);
        chk($sformatf("v%0d_a%0d_stable", vi, i), {31'h0, log_q[i].stable}, 1);
        if (i > 0) chk($sformatf("v%0d_a%0d_gap1", vi, i), {31'h0, log_q[i].gap >= 1}, 1);
        if (i > 0 && !exp_q[i].we && exp_q[i].adr == 8'h30 && !exp_q[i-1].we && exp_q[i-1].adr == 8'h30)
          chk($sformatf("v%0d_a%0d_pollgap", vi, i), {31'h0, log_q[i].gap >= GAP}, 1);
      end
      chk($sformatf("v%0d_sel", vi), sel_err, 0);
      $display("vec %0d: cmd=%h arg=%h status=%b resp=%h eisr=%h accesses=%0d done@%0d",
               vi, v.cmd, v.arg, status_o, resp_o, eisr_o, log_q.size(), dc);
      step();
      chk($sformatf("v%0d_busy_after", vi), {31'h0, busy_o}, 0);
      chk($sformatf("v%0d_done_after", vi), {31'h0, done_o}, 0);
      chk($sformatf("v%0d_status_held", vi), {30'h0, status_o}, {30'h0, v.exp_status});
      step();
    end

    // req_i held high: one sequence, re-accepted in the IDLE cycle after DONE
    cfg_zero_polls = 0; cfg_nisr = 16'h0001; cfg_resp = 32'h0000_0900; cfg_arg_delay = 1;
    nisr_reads = 0; log_q.delete(); d0 = done_cnt;
    req_cmd_i = 16'h0119; req_arg_i = 32'h0000_0800; req_i = 1'b1;
    step();
    t0 = cyc_cnt;
    wait_done(400, t0, dc, ok);
    chk("hold_done_cycle", dc, 15);
    chk("hold_acc_first", log_q.size(), 5);
    step();
    chk("hold_idle_busy", {31'h0, busy_o}, 0);
    step();
    chk("hold_reaccept_busy", {31'h0, busy_o}, 1);
    req_i = 1'b0;
    wait_done(400, cyc_cnt, dc, ok);
    chk("hold_second_done", {31'h0, ok}, 1);
    step(); step();
    chk("hold_done_pulses", done_cnt - d0, 2);
    chk("hold_acc_total", log_q.size(), 10);
    $display("req-hold: two sequences, accesses=%0d", log_q.size());

    // Never-completing command: timeout when enabled, unbounded polling otherwise
    cfg_zero_polls = 1000000; cfg_nisr = 16'h0000;
    nisr_reads = 0; log_q.delete(); d0 = done_cnt;
    start_cmd(16'h0D1A, 32'h0, t0);
`ifdef SD_CMD_ISSUER_TIMEOUT_EN
    wait_done(1000, t0, dc, ok);
    chk("to_done_seen", {31'h0, ok}, 1);
    chk("to_done_cycle", dc, 61);
    chk("to_status", {30'h0, status_o}, 2);
    chk("to_polls", nisr_reads, PMAX);
    chk("to_resp", resp_o, 0);
    chk("to_acc_count", log_q.size(), PMAX + 3);
    if (log_q.size() > 0) begin
      chk("to_last_adr", {24'h0, log_q[log_q.size()-1].adr}, 32'h30);
      chk("to_last_we", {31'h0, log_q[log_q.size()-1].we}, 1);
    end
    $display("timeout: polls=%0d status=%b", nisr_reads, status_o);
    step(); step();
`else
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (nisr_reads >= 100) begin ok = 1'b1; break; end
      step();
    end
    chk("poll_100_reached", {31'h0, ok}, 1);
    chk("poll_busy", {31'h0, busy_o}, 1);
    chk("poll_no_done", done_cnt - d0, 0);
    $display("no-timeout: polls=%0d busy=%b", nisr_reads, busy_o);
    apply_reset(2);
`endif

    // Reset during an RD_NISR strobe
    cfg_zero_polls = 1000000; nisr_reads = 0; d0 = done_cnt;
    start_cmd(16'h0119, 32'h1, t0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (wbm_stb_o && !wbm_we_o && wbm_adr_o == 8'h30) begin ok = 1'b1; break; end
      step();
    end
    chk("rstmid_found_nisr", {31'h0, ok}, 1);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("rstmid_cyc", {31'h0, wbm_cyc_o}, 0);
    chk("rstmid_stb", {31'h0, wbm_stb_o}, 0);
    step();
    wb_rst_i = 1'b1;
    repeat (30) step();
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_status", {30'h0, status_o}, 0);
    chk("rstmid_busy", {31'h0, busy_o}, 0);
    chk("rstmid_bus_idle", {31'h0, wbm_cyc_o}, 0);
    $display("reset-mid-access: done pulses=%0d status=%b", done_cnt - d0, status_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
